// File: rtl/fle_ccff_loader.sv
// Purpose: collects a config bitstream in WORD_W-bit words, shifts CHAIN_LEN bits into the fle ccff chain, then re-shifts the same bits to verify ccff_tail.
// Latency: done pulses 2*CHAIN_LEN+2 cycles after the last accepted word.
// Backpressure: cfg_ready is high only in FILL until CHAIN_LEN bits are held; words offered in any other state are not taken.
module fle_ccff_loader #(
    parameter  int CHAIN_LEN = 20,
    parameter  int WORD_W    = 8,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        VERIFY,
        DONE
    } state_t;

    state_t               state;
    logic [CHAIN_LEN-1:0] sh;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     idx;

    logic [CHAIN_LEN-1:0] ins_bits;
    logic [CHAIN_LEN-1:0] ins_mask;
    logic [CHAIN_LEN-1:0] sh_fill;
    logic [CHAIN_LEN-1:0] sh_rot;
    logic [CNT_W+5:0]     cnt_sum;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 idx_last;

    // Bits of the word that land beyond CHAIN_LEN fall off the top of the shift.
    assign ins_bits = CHAIN_LEN'(cfg_data) << cnt;
    assign ins_mask = CHAIN_LEN'({WORD_W{1'b1}}) << cnt;
    assign sh_fill  = (sh & ~ins_mask) | (ins_bits & ins_mask);

    // Rotating the shadow presents the next stream bit at sh[0] without a variable index.
    assign sh_rot   = {sh[0], sh[CHAIN_LEN-1:1]};

    assign cnt_sum  = (CNT_W+6)'(cnt) + (CNT_W+6)'(WORD_W);
    assign cnt_nxt  = (cnt_sum >= (CNT_W+6)'(CHAIN_LEN)) ? CNT_W'(CHAIN_LEN)
                                                         : cnt_sum[CNT_W-1:0];
    assign idx_last = (idx == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state         <= IDLE;
            sh            <= '0;
            cnt           <= '0;
            idx           <= '0;
            cfg_ready     <= 1'b0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        err       <= 1'b0;
                        cnt       <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt == CNT_W'(CHAIN_LEN)) begin
                        state         <= SHIFT;
                        idx           <= '0;
                        ccff_head     <= sh[0];
                        ccff_shift_en <= 1'b1;
                        sh            <= sh_rot;
                    end else if (cfg_valid && cfg_ready) begin
                        sh        <= sh_fill;
                        cnt       <= cnt_nxt;
                        cfg_ready <= (cnt_nxt != CNT_W'(CHAIN_LEN));
                    end
                end
                SHIFT: begin
                    ccff_head <= sh[0];
                    sh        <= sh_rot;
                    if (idx_last) begin
                        state <= VERIFY;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                VERIFY: begin
                    // The bit leaving the chain now is the one entering it: a full-depth FIFO.
                    if (ccff_tail != ccff_head) begin
                        err <= 1'b1;
                    end
                    if (idx_last) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        ccff_shift_en <= 1'b0;
                        ccff_head     <= 1'b0;
                    end else begin
                        ccff_head <= sh[0];
                        sh        <= sh_rot;
                        idx       <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fle_ccff_loader.sv
// Purpose: drives word loads into fle_ccff_loader against a behavioural 20-flop chain and scores each done.
// Latency: expects done 42 cycles after the final handshake.
// Backpressure: offers words with valid held or toggling and keeps offering junk after the last word.
module tb_fle_ccff_loader;

    localparam int CL = 20;
    localparam int WW = 8;

    logic          prog_clk;
    logic          pReset_n;
    logic          start;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          err;

    fle_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    typedef struct {
        logic [CL-1:0] chain;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            hs_cnt = 0;
    int            hs_cyc = 0;
    int            done_cnt = 0;
    int            shcnt = 0;
    bit            flip = 1'b0;
    logic [CL-1:0] chain = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Stream bit i enters first, so after CL shifts it sits at chain[CL-1-i].
    function automatic logic [CL-1:0] exp_chain(input logic [23:0] w);
        logic [CL-1:0] r;
        for (int i = 0; i < CL; i++) r[CL-1-i] = w[i];
        return r;
    endfunction

    // Behavioural chain; optionally corrupts the tail during verify bit 7.
    always @(posedge prog_clk) begin
        cyc++;
        if (start && !busy) shcnt <= 0;
        else if (ccff_shift_en) shcnt <= shcnt + 1;
        if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
    end
    assign ccff_tail = chain[CL-1] ^ (flip && shcnt == CL + 7);

    always @(negedge prog_clk) begin
        exp_t e;
        if (pReset_n && start && !busy) hs_cnt = 0;
        else if (cfg_valid && cfg_ready) begin
            hs_cnt++;
            hs_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) chk("sb_underflow", 0, 1);
            else begin
                e = sb.pop_front();
                chk("chain", 32'(chain), 32'(e.chain));
                chk("err", 32'(err), 32'(e.err));
                chk("handshakes", hs_cnt, 3);
                chk("latency", cyc - hs_cyc, 2 * CL + 2);
                chk("rdy_done", 32'(cfg_ready), 0);
            end
        end
    end

    task automatic pulse_start(input bit with_valid);
        @(posedge prog_clk); #1;
        start = 1'b1;
        cfg_valid = with_valid;
        cfg_data = 8'h77;
        @(negedge prog_clk);
        chk("rdy_idle", 32'(cfg_ready), 0);
        chk("busy_idle", 32'(busy), 0);
        @(posedge prog_clk); #1;
        start = 1'b0;
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        chk("err_clr", 32'(err), 0);
        chk("busy_fill", 32'(busy), 1);
    endtask

    task automatic feed(input logic [23:0] w, input bit tog);
        int i;
        int guard;
        bit ph;
        logic [23:0] ww;
        i = 0; guard = 0; ph = 1'b1; ww = w;
        while (i < 3 && guard < 100) begin
            @(posedge prog_clk); #1;
            cfg_valid = tog ? ph : 1'b1;
            ph = !ph;
            cfg_data = ww[i*8 +: 8];
            @(negedge prog_clk);
            if (cfg_valid && cfg_ready) i++;
            guard++;
        end
        if (i < 3) chk("feed_timeout", i, 3);
        repeat (3) begin
            @(posedge prog_clk); #1;
            cfg_valid = 1'b1;
            cfg_data = 8'hFF;
        end
        @(posedge prog_clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic load(input logic [23:0] w, input bit tog, input bit flp, input bit sv);
        exp_t e;
        flip = flp;
        e.chain = exp_chain(w);
        e.err = flp;
        sb.push_back(e);
        pulse_start(sv);
        feed(w, tog);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (guard < 200) begin
            @(negedge prog_clk);
            if (done) break;
            guard++;
        end
        if (guard >= 200) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int d0;
        pReset_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        chk("rst_outs", 32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, err}), 0);
        @(posedge prog_clk); #1;
        pReset_n = 1'b1;

        load(24'hF93CA5, 1'b0, 1'b0, 1'b1);
        wait_done();
        load(24'hF93CA5, 1'b1, 1'b0, 1'b0);
        wait_done();

        load(24'h5A1E0F, 1'b0, 1'b1, 1'b0);
        wait_done();
        @(negedge prog_clk);
        chk("err_sticky", 32'(err), 1);
        flip = 1'b0;

        load(24'h00C3E7, 1'b0, 1'b0, 1'b0);
        d0 = done_cnt;
        repeat (8) @(posedge prog_clk);
        #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        repeat (24) @(posedge prog_clk);
        #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        wait_done();
        repeat (60) @(negedge prog_clk);
        chk("single_done", done_cnt - d0, 1);
        chk("busy_after", 32'(busy), 0);

        load(24'h123456, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge prog_clk);
        #1 pReset_n = 1'b0;
        @(posedge prog_clk); #1 pReset_n = 1'b1;
        @(negedge prog_clk);
        chk("rst_mid_outs", 32'({cfg_ready, ccff_head, ccff_shift_en, busy, done, err}), 0);
        void'(sb.pop_back());
        d0 = done_cnt;
        repeat (50) @(negedge prog_clk);
        chk("no_done_abort", done_cnt - d0, 0);
        load(24'hABCDEF, 1'b1, 1'b0, 1'b0);
        wait_done();

        load(24'h0F0F0F, 1'b0, 1'b0, 1'b0);
        wait_done();
        load(24'hF0C3A9, 1'b0, 1'b0, 1'b0);
        wait_done();

        repeat (4) @(negedge prog_clk);
        chk("sb_drained", sb.size(), 0);
        chk("done_total", done_cnt, 7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
